// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder slice.
// Latency: n/a. Backpressure: n/a.
package cpu_mem_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_DEPTH   = 32;
    localparam int DEF_LATENCY = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
// Latency: n/a. Backpressure: req_ready_o/stall_o from the responder side.
// Optional err_o exists only when DMEM_ADDR_CHECK_EN is defined.
interface dmem_responder_if;
    import cpu_mem_pkg::*;

    logic  req_valid_i;
    logic  req_write_i;
    word_t req_addr_i;
    word_t req_wdata_i;
    logic  req_ready_o;
    logic  stall_o;
    logic  resp_valid_o;
    word_t resp_rdata_o;
`ifdef DMEM_ADDR_CHECK_EN
    logic  err_o;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output req_ready_o, stall_o, resp_valid_o, resp_rdata_o, err_o
    );
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  req_ready_o, stall_o, resp_valid_o, resp_rdata_o, err_o
    );
`else
    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output req_ready_o, stall_o, resp_valid_o, resp_rdata_o
    );
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  req_ready_o, stall_o, resp_valid_o, resp_rdata_o
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: synchronous write, registered read, async clear.
// Latency: read data appears one edge after re_i. Backpressure: none.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic          rd_zero_i,
    input  logic [AW-1:0] idx_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];
    word_t rdata_q;
    word_t rdata_d;

    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we_i) begin
            mem_d[idx_i] = wdata_i;
        end
        // rd_zero_i lets the caller return a clean zero for rejected loads
        if (re_i) begin
            rdata_d = rd_zero_i ? '0 : mem_q[idx_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for MEM-stage loads/stores (DMEM_ADDR_CHECK_EN adds err_o).
// Latency: resp_valid_o rises LATENCY edges after the accepting edge; one request in flight.
// Backpressure: req_ready_o low and stall_o high until the response cycle.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    dmem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [AW-1:0]   idx_q, idx_d;
    word_t           wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            req_err;
    logic            do_access;
    word_t           arr_rdata;

`ifdef DMEM_ADDR_CHECK_EN
    assign req_err = (bus.req_addr_i[1:0] != 2'b00) ||
                     (bus.req_addr_i[WORD_W-1:AW+2] != '0);
`else
    // Address bits outside the word index are intentionally ignored (wrap).
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr_i[WORD_W-1:AW+2], bus.req_addr_i[1:0]};
    assign req_err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    write_d = bus.req_write_i;
                    idx_d   = bus.req_addr_i[AW+1:2];
                    wdata_d = bus.req_wdata_i;
                    err_d   = req_err;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .we_i      (do_access & write_q & ~err_q),
        .re_i      (do_access & ~write_q),
        .rd_zero_i (err_q),
        .idx_i     (idx_q),
        .wdata_i   (wdata_q),
        .rdata_o   (arr_rdata)
    );

    // stall drops in RESP so MEM_WB captures resp_rdata_o that cycle
    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.stall_o      = ((state_q == IDLE) && bus.req_valid_i) || (state_q == WAIT);
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_rdata_o = arr_rdata;
`ifdef DMEM_ADDR_CHECK_EN
    assign bus.err_o        = (state_q == RESP) && err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model results, negedge monitor pops/compares.
module tb_dmem_responder;
    import cpu_mem_pkg::*;

    localparam int DEPTH = 32;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        word_t rdata;
        logic  err;
    } exp_t;

    int    total    = 0;
    int    bad      = 0;
    int    cyc      = 0;
    int    last_acc = -100;
    word_t ref_mem [DEPTH];
    word_t ref_last = '0;
    word_t mon_hold = '0;
    exp_t  q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit ref_err(input word_t a);
`ifdef DMEM_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    // Model: busy for LAT cycles after acceptance, then one response cycle.
    always @(negedge clk) begin : monitor
        int   c;
        bit   busy, in_resp, idle;
        exp_t e;
        if (rst_n) begin
            c       = cyc;
            busy    = (c >= last_acc) && (c < last_acc + LAT);
            in_resp = (c == last_acc + LAT);
            idle    = !busy && !in_resp;
            chk("ready", bus.req_ready_o, idle);
            chk("stall", bus.stall_o, busy || (idle && bus.req_valid_i));
            chk("resp_valid", bus.resp_valid_o, in_resp);
            if (bus.resp_valid_o) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_unexpected: got resp with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", bus.resp_rdata_o, e.rdata);
`ifdef DMEM_ADDR_CHECK_EN
                    chk("err", bus.err_o, e.err);
`endif
                    mon_hold = e.rdata;
                end
            end else begin
                chk("rdata_hold", bus.resp_rdata_o, mon_hold);
`ifdef DMEM_ADDR_CHECK_EN
                chk("err_idle", bus.err_o, 1'b0);
`endif
            end
        end
    end

    task automatic idle_cycles(input int n);
        bus.req_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request from posedge+1, wait for the model to say it is accepted.
    task automatic do_req(input logic w, input word_t a, input word_t d, input bit pert, input bit keep);
        int   n;
        int   idx;
        bit   go;
        bit   er;
        exp_t e;
        n = 0;
        bus.req_write_i = w;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        bus.req_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            go = !((cyc >= last_acc) && (cyc <= last_acc + LAT));
            @(posedge clk);
            if (go) break;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: request not accepted within 50 cycles");
                bus.req_valid_i = 1'b0;
                #1;
                return;
            end
        end
        #1;
        last_acc = cyc;
        er  = ref_err(a);
        idx = int'((a >> 2) % DEPTH);
        if (w) begin
            if (!er) ref_mem[idx] = d;
        end else begin
            ref_last = er ? '0 : ref_mem[idx];
        end
        e.rdata = ref_last;
        e.err   = er;
        q.push_back(e);
        if (pert) begin
            bus.req_addr_i  = $urandom;
            bus.req_wdata_i = $urandom;
            bus.req_write_i = 1'($urandom_range(0, 1));
        end
        if (!keep) bus.req_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.req_ready_o, 1'b1);
        chk({tag, "_resp_valid"}, bus.resp_valid_o, 1'b0);
        chk({tag, "_rdata"}, bus.resp_rdata_o, 32'h0);
        chk({tag, "_stall"}, bus.stall_o, 1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a1;
        int a2;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Store then load the same word; load after reset returns zero; address wrap.
        do_req(1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_req(1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h1C, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 32'h80, 32'hCAFE_0001, 1'b0, 1'b0);
        do_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle_cycles(3);

        // Back-to-back with valid held through WAIT/RESP.
        do_req(1'b1, 32'h10, 32'h1111_2222, 1'b0, 1'b1);
        a1 = last_acc;
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        a2 = last_acc;
        chk("spacing", a2 - a1, LAT + 2);
        idle_cycles(2);

        // Request inputs scrambled after acceptance must not matter.
        do_req(1'b1, 32'h14, 32'hA5A5_5A5A, 1'b1, 1'b1);
        idle_cycles(4);
        do_req(1'b0, 32'h14, 32'h0, 1'b1, 1'b0);
        idle_cycles(4);

        // Reset in WAIT during a store: dropped, array cleared.
        do_req(1'b1, 32'h4, 32'h1234_5678, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        last_acc = -100;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_last = '0;
        mon_hold = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);
        do_req(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
        idle_cycles(2);

`ifdef DMEM_ADDR_CHECK_EN
        do_req(1'b1, 32'h4, 32'h0000_00A5, 1'b0, 1'b0);
        do_req(1'b1, 32'h6, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_req(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h84, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        idle_cycles(2);
`endif

        // Randomized traffic: in-range, aliased upper bits and fully random addresses.
        for (int i = 0; i < 300; i++) begin
            word_t a;
            int    sel;
            sel = $urandom_range(0, 3);
            if (sel < 2)
                a = word_t'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 2)
                a = ($urandom & ~word_t'(DEPTH * 4 - 1)) | word_t'($urandom_range(0, DEPTH - 1) * 4);
            else
                a = $urandom;
            do_req(1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(0, 3));
        end

        idle_cycles(LAT + 4);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
